// File: rtl/imm_extend_pipe.sv
// Two-stage immediate-extension unit for the ARM datapath.
// It decodes the 24-bit instruction immediate field into a DATA_W operand and the
// matching shifter carry. Beats move through a valid/ready pipeline that supports
// backpressure and flush.
module imm_extend_pipe #(
    parameter int DATA_W = 32,
    parameter bit ROT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        ImmSrc,
    input  logic [23:0]       Extend_in,
    input  logic              CarryIn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ExtImm,
    output logic              CarryOut
);

    // Rotate right within 32 bits. Shifting the doubled word avoids a shift by 32
    // when the amount is zero.
    function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
        return 32'({v, v} >> amt);
    endfunction

    // Build {carry, value} for one decoded beat.
    function automatic logic [DATA_W:0] extendImm(
        input logic [1:0]  src,
        input logic [23:0] ext,
        input logic        cin,
        input logic [4:0]  amt
    );
        logic [31:0]              rotated;
        logic signed [25:0]       brOff;
        logic signed [DATA_W-1:0] brExt;
        logic [DATA_W:0]          res;
        rotated = ror32({24'd0, ext[7:0]}, amt);
        brOff   = signed'({ext, 2'b00});
        brExt   = DATA_W'(brOff);
        case (src)
            // A zero rotate amount leaves the C flag untouched.
            2'b00:   res = {(amt == 5'd0) ? cin : rotated[31], DATA_W'(rotated)};
            2'b01:   res = {cin, DATA_W'(ext[11:0])};
            2'b10:   res = {cin, brExt};
            default: res = {cin, DATA_W'({ext[11:8], ext[3:0]})};
        endcase
        return res;
    endfunction

    logic              vld_p1;
    logic [1:0]        immSrc_p1;
    logic [23:0]       extendIn_p1;
    logic              carryIn_p1;
    logic [4:0]        rotAmt_p1;
    logic              vld_p2;
    logic              adv2;
    logic              adv1;
    logic              accept;
    logic [4:0]        rotAmtIn;
    logic [DATA_W:0]   extResult;

    assign adv2      = !vld_p2 || out_ready;
    assign adv1      = vld_p1 && adv2;
    assign in_ready  = !flush && (!vld_p1 || adv2);
    assign accept    = in_valid && in_ready;
    assign out_valid = vld_p2;
    assign rotAmtIn  = ROT_EN ? {Extend_in[11:8], 1'b0} : 5'd0;
    assign extResult = extendImm(immSrc_p1, extendIn_p1, carryIn_p1, rotAmt_p1);

    // Stage 1 occupancy: fill on accept, empty when the beat moves on.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (adv1) begin
            vld_p1 <= 1'b0;
        end
    end

    // Stage 1 data capture, including the pre-decoded rotate amount.
    always_ff @(posedge clk) begin
        if (accept) begin
            immSrc_p1   <= ImmSrc;
            extendIn_p1 <= Extend_in;
            carryIn_p1  <= CarryIn;
            rotAmt_p1   <= rotAmtIn;
        end
    end

    // Stage 2: extend and register the result. Output is held while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2   <= 1'b0;
            ExtImm   <= '0;
            CarryOut <= 1'b0;
        end else if (flush) begin
            vld_p2 <= 1'b0;
        end else if (adv2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                {CarryOut, ExtImm} <= extResult;
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: three instances run side by side.
// They are 32-bit with rotation, 64-bit with rotation, and 32-bit without rotation.
module tb_imm_extend_pipe;

    typedef struct {
        logic [1:0]  src;
        logic [23:0] ext;
        logic        cin;
        logic [31:0] e32;
        logic        c32;
        logic [63:0] e64;
        logic [31:0] enr;
        logic        cnr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready, CarryIn;
    logic [1:0]  ImmSrc;
    logic [23:0] Extend_in;
    logic        rdyA, vldA, cA, rdyB, vldB, cB, rdyC, vldC, cC;
    logic [31:0] extA, extC;
    logic [63:0] extB;

    int checks = 0;
    int errors = 0;
    vec_t vecs[12];

    always #5 clk = ~clk;

    imm_extend_pipe #(.DATA_W(32), .ROT_EN(1'b1)) dutA (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdyA),
        .ImmSrc(ImmSrc), .Extend_in(Extend_in), .CarryIn(CarryIn), .out_valid(vldA),
        .out_ready(out_ready), .ExtImm(extA), .CarryOut(cA));

    imm_extend_pipe #(.DATA_W(64), .ROT_EN(1'b1)) dutB (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdyB),
        .ImmSrc(ImmSrc), .Extend_in(Extend_in), .CarryIn(CarryIn), .out_valid(vldB),
        .out_ready(out_ready), .ExtImm(extB), .CarryOut(cB));

    imm_extend_pipe #(.DATA_W(32), .ROT_EN(1'b0)) dutC (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdyC),
        .ImmSrc(ImmSrc), .Extend_in(Extend_in), .CarryIn(CarryIn), .out_valid(vldC),
        .out_ready(out_ready), .ExtImm(extC), .CarryOut(cC));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic driveBeat(input vec_t v);
        ImmSrc    = v.src;
        Extend_in = v.ext;
        CarryIn   = v.cin;
    endtask

    task automatic checkOut(input string tag, input vec_t v);
        chk({tag, " vldA"}, 64'(vldA), 64'd1);
        chk({tag, " extA"}, 64'(extA), 64'(v.e32));
        chk({tag, " cA"},   64'(cA),   64'(v.c32));
        chk({tag, " vldB"}, 64'(vldB), 64'd1);
        chk({tag, " extB"}, extB,      v.e64);
        chk({tag, " cB"},   64'(cB),   64'(v.c32));
        chk({tag, " vldC"}, 64'(vldC), 64'd1);
        chk({tag, " extC"}, 64'(extC), 64'(v.enr));
        chk({tag, " cC"},   64'(cC),   64'(v.cnr));
    endtask

    int bp[4]      = '{1, 3, 0, 4};
    int expRdy[9]  = '{1, 1, 0, 0, 1, 1, 1, 1, 1};
    int expIdx[9]  = '{-1, -1, 0, 0, 0, 1, 2, 3, -1};
    int nb;

    initial begin
        //          src    ext          cin   e32            c32   e64                     enr            cnr
        vecs[0]  = '{2'b10, 24'h82411A, 1'b1, 32'hFE090468, 1'b1, 64'hFFFFFFFF_FE090468, 32'hFE090468, 1'b1};
        vecs[1]  = '{2'b00, 24'h0004FF, 1'b0, 32'hFF000000, 1'b1, 64'h00000000_FF000000, 32'h000000FF, 1'b0};
        vecs[2]  = '{2'b00, 24'h0000AB, 1'b1, 32'h000000AB, 1'b1, 64'h00000000_000000AB, 32'h000000AB, 1'b1};
        vecs[3]  = '{2'b01, 24'h82411A, 1'b0, 32'h0000011A, 1'b0, 64'h00000000_0000011A, 32'h0000011A, 1'b0};
        vecs[4]  = '{2'b11, 24'h82411A, 1'b1, 32'h0000001A, 1'b1, 64'h00000000_0000001A, 32'h0000001A, 1'b1};
        vecs[5]  = '{2'b00, 24'h000F01, 1'b0, 32'h00000004, 1'b0, 64'h00000000_00000004, 32'h00000001, 1'b0};
        vecs[6]  = '{2'b00, 24'h000102, 1'b0, 32'h80000000, 1'b1, 64'h00000000_80000000, 32'h00000002, 1'b0};
        vecs[7]  = '{2'b10, 24'h000001, 1'b0, 32'h00000004, 1'b0, 64'h00000000_00000004, 32'h00000004, 1'b0};
        vecs[8]  = '{2'b10, 24'h800000, 1'b1, 32'hFE000000, 1'b1, 64'hFFFFFFFF_FE000000, 32'hFE000000, 1'b1};
        vecs[9]  = '{2'b01, 24'hFFFFFF, 1'b0, 32'h00000FFF, 1'b0, 64'h00000000_00000FFF, 32'h00000FFF, 1'b0};
        vecs[10] = '{2'b11, 24'hFFFFFF, 1'b1, 32'h000000FF, 1'b1, 64'h00000000_000000FF, 32'h000000FF, 1'b1};
        vecs[11] = '{2'b00, 24'hFFF3C0, 1'b1, 32'h00000003, 1'b0, 64'h00000000_00000003, 32'h000000C0, 1'b1};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ImmSrc = 2'b00; Extend_in = 24'd0; CarryIn = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst vldA", 64'(vldA), 64'd0);
        chk("rst rdyA", 64'(rdyA), 64'd1);
        chk("rst extA", 64'(extA), 64'd0);
        chk("rst cA",   64'(cA),   64'd0);
        chk("rst vldB", 64'(vldB), 64'd0);
        chk("rst rdyB", 64'(rdyB), 64'd1);
        chk("rst extB", extB,      64'd0);
        chk("rst rdyC", 64'(rdyC), 64'd1);
        chk("rst vldC", 64'(vldC), 64'd0);

        // Single beats: accepted at one edge, visible after the next.
        for (int i = 0; i < 12; i++) begin
            driveBeat(vecs[i]);
            in_valid = 1'b1;
            #1;
            chk($sformatf("v%0d rdy", i), 64'(rdyA), 64'd1);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk($sformatf("v%0d early vld", i), 64'(vldA), 64'd0);
            @(negedge clk);
            #1;
            checkOut($sformatf("v%0d", i), vecs[i]);
        end
        repeat (2) @(negedge clk);

        // Backpressure: four beats offered, consumer stalled for four cycles.
        nb = 0;
        for (int c = 0; c < 9; c++) begin
            out_ready = (c >= 4);
            in_valid  = (nb < 4);
            if (nb < 4) driveBeat(vecs[bp[nb]]);
            #1;
            chk($sformatf("bp c%0d rdy", c), 64'(rdyA), 64'(expRdy[c]));
            chk($sformatf("bp c%0d vld", c), 64'(vldA), 64'(expIdx[c] >= 0));
            if (expIdx[c] >= 0) begin
                chk($sformatf("bp c%0d ext", c), 64'(extA), 64'(vecs[bp[expIdx[c]]].e32));
                chk($sformatf("bp c%0d carry", c), 64'(cA), 64'(vecs[bp[expIdx[c]]].c32));
            end
            if (in_valid && rdyA) nb++;
            if (c == 3) chk("bp accepted while stalled", 64'(nb), 64'd2);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp accepted total", 64'(nb), 64'd4);

        // Flush with two beats in flight, plus a beat offered during the flush.
        out_ready = 1'b0;
        driveBeat(vecs[5]); in_valid = 1'b1;
        @(negedge clk);
        driveBeat(vecs[6]);
        @(negedge clk);
        flush = 1'b1;
        driveBeat(vecs[2]);
        #1;
        chk("flush rdy", 64'(rdyA), 64'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("flush vld", 64'(vldA), 64'd0);
        chk("flush data held", 64'(extA), 64'(vecs[5].e32));
        chk("flush rdy after", 64'(rdyA), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("flush idle%0d vld", k), 64'(vldA), 64'd0);
        end
        driveBeat(vecs[7]); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("post flush early vld", 64'(vldA), 64'd0);
        @(negedge clk);
        #1;
        checkOut("post flush", vecs[7]);
        @(negedge clk);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        driveBeat(vecs[0]); in_valid = 1'b1;
        @(negedge clk);
        driveBeat(vecs[1]);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid rst vld", 64'(vldA), 64'd0);
        chk("mid rst extA", 64'(extA), 64'd0);
        chk("mid rst cA", 64'(cA), 64'd0);
        chk("mid rst extB", extB, 64'd0);
        chk("mid rst rdy", 64'(rdyA), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("mid rst idle%0d vld", k), 64'(vldA), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
